// File: rtl/store_rmw.sv
`default_nettype none
// ============================================================================
// Module      : store_rmw
// Description : SB/SH/SW store engine for a word-wide RAM without byte
//               enables; sub-word stores are done as read-merge-write.
// Revision    : 1.0 - initial release
// ============================================================================
module store_rmw #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    input  logic [2:0]         req_addrmode,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_rd_en,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               mem_wr_en,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic               done,
    output logic               err
);

    localparam logic [2:0] c_MODE_SB = 3'b000;
    localparam logic [2:0] c_MODE_SH = 3'b001;
    localparam logic [2:0] c_MODE_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_rd_en;
    logic               r_wr_en;
    logic               r_done;
    logic               r_err;
    logic [A_WIDTH-1:0] r_mem_addr;
    logic [1:0]         r_lane;
    logic [2:0]         r_mode;
    logic [D_WIDTH-1:0] r_wdata;
    logic [D_WIDTH-1:0] r_merge;

    logic               w_sub_ok;
    logic               w_sw_ok;
    logic [A_WIDTH-1:0] w_word_addr;
    logic [D_WIDTH-1:0] w_merged;

    // Legality is judged on the live request so the next state is known at accept.
    assign w_sub_ok    = (req_addrmode == c_MODE_SB) ||
                         ((req_addrmode == c_MODE_SH) && !req_addr[0]);
    assign w_sw_ok     = (req_addrmode == c_MODE_SW) && (req_addr[1:0] == 2'b00);
    assign w_word_addr = {req_addr[A_WIDTH-1:2], 2'b00};

    always_comb begin
        w_merged = mem_rdata;
        case (r_mode)
            c_MODE_SB: w_merged[{r_lane, 3'b000} +: 8]        = r_wdata[7:0];
            c_MODE_SH: w_merged[{r_lane[1], 4'b0000} +: 16]   = r_wdata[15:0];
            default:   w_merged                               = r_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_lane     <= '0;
            r_mode     <= '0;
            r_wdata    <= '0;
            r_merge    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_lane  <= req_addr[1:0];
                        r_mode  <= req_addrmode;
                        r_wdata <= req_wdata;
                        r_ready <= 1'b0;
                        if (w_sub_ok) begin
                            r_state    <= S_READ;
                            r_rd_en    <= 1'b1;
                            r_mem_addr <= w_word_addr;
                        end else if (w_sw_ok) begin
                            r_state    <= S_WRITE;
                            r_wr_en    <= 1'b1;
                            r_done     <= 1'b1;
                            r_mem_addr <= w_word_addr;
                            r_merge    <= req_wdata;
                        end else begin
                            r_state <= S_ERR;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_MERGE;
                    r_rd_en <= 1'b0;
                end
                // RAM read data is valid during this state; fold it in on exit.
                S_MERGE: begin
                    r_state <= S_WRITE;
                    r_merge <= w_merged;
                    r_wr_en <= 1'b1;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_rd_en <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign mem_rd_en = r_rd_en;
    assign mem_wr_en = r_wr_en;
    assign done      = r_done;
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_merge;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_rmw
// Description : Directed bench for store_rmw with a RAM model and a queue of
//               expected completions checked on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_rmw;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_addrmode;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          errors;
    int          checks;
    int          done_cnt;
    int          push_cnt;
    logic        mon_en;
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;
    logic [31:0] ram [0:1023];
    logic [31:0] b2b_exp;

    store_rmw #(.D_WIDTH(32), .A_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_addrmode (req_addrmode),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rdata    (mem_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with a backdoor preload port
    always @(posedge clk) begin
        if (bd_we)
            ram[bd_idx] <= bd_data;
        else if (mem_wr_en)
            ram[mem_addr[11:2]] <= mem_wdata;
        if (mem_rd_en)
            mem_rdata <= ram[mem_addr[11:2]];
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic e, input logic [31:0] a, input logic [31:0] d);
        exp_t x;
        x.err  = e;
        x.addr = a;
        x.data = d;
        sb_q.push_back(x);
        push_cnt++;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_idx  = a[11:2];
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Drives a request and returns just after the edge that accepted it
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = a;
        req_wdata    = d;
        req_addrmode = m;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check1("accept_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_req();
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        check1("return_idle", req_ready, 1'b1);
    endtask

    // Completion monitor: every done must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            exp_t e;
            check1("rd_wr_exclusive", mem_rd_en & mem_wr_en, 1'b0);
            check1("wr_implies_done", mem_wr_en & ~done, 1'b0);
            if (done) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_done: observed=done expected=no_done");
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    done_cnt++;
                    check1("done_err", err, e.err);
                    check1("done_wr_en", mem_wr_en, ~e.err);
                    if (!e.err) begin
                        check32("wr_addr", mem_addr, e.addr);
                        check32("wr_data", mem_wdata, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0; checks = 0; done_cnt = 0; push_cnt = 0;
        mon_en = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_addrmode = '0;

        // Asynchronous reset between edges
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check1("rst_ready", req_ready, 1'b1);
        check1("rst_rd_en", mem_rd_en, 1'b0);
        check1("rst_wr_en", mem_wr_en, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("ready_after_release", req_ready, 1'b1);
        mon_en = 1'b1;

        // SB with cycle-exact latency checks
        preload(32'h100, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h102; req_wdata = 32'hFFFFFFAB; req_addrmode = 3'b000;
        push_exp(1'b0, 32'h100, 32'h11AB3344);
        @(negedge clk);
        req_valid = 1'b0;
        check1("sb_read_rd_en", mem_rd_en, 1'b1);
        check1("sb_read_wr_en", mem_wr_en, 1'b0);
        check1("sb_read_ready", req_ready, 1'b0);
        check32("sb_read_addr", mem_addr, 32'h100);
        @(negedge clk);
        check1("sb_merge_rd_en", mem_rd_en, 1'b0);
        check1("sb_merge_wr_en", mem_wr_en, 1'b0);
        @(negedge clk);
        check1("sb_write_wr_en", mem_wr_en, 1'b1);
        check1("sb_write_done", done, 1'b1);
        @(negedge clk);
        check1("sb_after_done", done, 1'b0);
        check1("sb_after_ready", req_ready, 1'b1);
        check32("sb_ram", ram[10'h040], 32'h11AB3344);

        // SH upper half, then misaligned SH
        preload(32'h200, 32'hDEADBEEF);
        push_exp(1'b0, 32'h200, 32'hCAFEBEEF);
        issue(32'h202, 32'h0000CAFE, 3'b001);
        finish_req();
        check32("sh_ram", ram[10'h080], 32'hCAFEBEEF);
        push_exp(1'b1, 32'h0, 32'h0);
        issue(32'h201, 32'h00001111, 3'b001);
        @(negedge clk);
        req_valid = 1'b0;
        check1("sh_mis_err", err, 1'b1);
        check1("sh_mis_done", done, 1'b1);
        check1("sh_mis_rd_en", mem_rd_en, 1'b0);
        @(negedge clk);
        check1("sh_mis_err_clear", err, 1'b0);
        check1("sh_mis_done_clear", done, 1'b0);
        check32("sh_mis_ram", ram[10'h080], 32'hCAFEBEEF);
        push_exp(1'b0, 32'h200, 32'hCAFE1234);
        issue(32'h200, 32'hFFFF1234, 3'b001);
        finish_req();

        // SW aligned, misaligned, illegal modes
        push_exp(1'b0, 32'h304, 32'h01234567);
        issue(32'h304, 32'h01234567, 3'b010);
        @(negedge clk);
        req_valid = 1'b0;
        check1("sw_wr_en", mem_wr_en, 1'b1);
        check1("sw_rd_en", mem_rd_en, 1'b0);
        check32("sw_addr", mem_addr, 32'h304);
        finish_req();
        check32("sw_ram", ram[10'h0C1], 32'h01234567);
        push_exp(1'b1, 32'h0, 32'h0);
        issue(32'h306, 32'h89ABCDEF, 3'b010);
        finish_req();
        push_exp(1'b1, 32'h0, 32'h0);
        issue(32'h300, 32'h89ABCDEF, 3'b011);
        finish_req();
        push_exp(1'b1, 32'h0, 32'h0);
        issue(32'h300, 32'h89ABCDEF, 3'b111);
        finish_req();
        check32("sw_ram_untouched", ram[10'h0C0] === 32'h89ABCDEF ? 32'h1 : 32'h0, 32'h0);

        // Back-to-back SBs with req_valid held
        preload(32'h400, 32'h0);
        b2b_exp = 32'h0;
        for (int i = 0; i < 4; i++) begin
            b2b_exp = b2b_exp | ((32'h0A + 32'(i)) << (8 * i));
            push_exp(1'b0, 32'h400, b2b_exp);
            issue(32'h400 + 32'(i), 32'h0A + 32'(i), 3'b000);
            @(negedge clk);
            check1("b2b_busy", req_ready, 1'b0);
        end
        finish_req();
        check32("b2b_ram", ram[10'h100], 32'h0D0C0B0A);

        // Reset during MERGE drops the request
        preload(32'h500, 32'h55667788);
        issue(32'h501, 32'h00000099, 3'b000);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check1("midrst_ready", req_ready, 1'b1);
        check1("midrst_wr_en", mem_wr_en, 1'b0);
        check1("midrst_done", done, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check1("midrst_hold_wr_en", mem_wr_en, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check32("midrst_ram", ram[10'h140], 32'h55667788);
        push_exp(1'b0, 32'h500, 32'h55669988);
        issue(32'h501, 32'h00000099, 3'b000);
        finish_req();
        check32("post_rst_ram", ram[10'h140], 32'h55669988);

        repeat (2) @(negedge clk);
        check32("queue_drained", 32'(sb_q.size()), 32'd0);
        check32("done_count", 32'(done_cnt), 32'(push_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
